axi_read_stripe_merger: RTL and testbench

Multi-channel read front end that sits between the memory controller read request interface and NUM_CH per-channel AXI read engines. One read request is split into fixed-length bursts, and the bursts are striped round-robin across all channels. Returned beats are buffered per channel and merged back into strict address order before the input buffer. This removes the single-channel read bottleneck: writes already spread across channels, and reads now do too.

---
 rtl/axi_read_stripe_merger.sv | 216 +++++++++++++++++++++
 tb/tb_axi_read_stripe_merger.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_stripe_merger.sv
// Read front end: splits one request into bursts striped round-robin over NUM_CH
// AXI read engines, then merges the returned beats back into address order.
//   state   | meaning
//   S_IDLE  | ready for a request
//   S_ISSUE | issuing bursts round-robin, gated by per-channel credit
//   S_DRAIN | all bursts issued, waiting for the last beat to be merged
module axi_read_stripe_merger #(
   parameter int NUM_CH     = 4,
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 64,
   parameter int TX_SIZE_W  = 10,
   parameter int BURST_LEN  = 16,
   parameter int FIFO_DEPTH = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     rd_req,
   output logic                     rd_ready,
   input  logic [ADDR_W-1:0]        rd_addr,
   input  logic [TX_SIZE_W-1:0]     rd_req_size,
   output logic                     rd_done,
   output logic [NUM_CH-1:0]        ch_req,
   input  logic [NUM_CH-1:0]        ch_ready,
   output logic [NUM_CH*ADDR_W-1:0] ch_addr,
   output logic [NUM_CH*4-1:0]      ch_len,
   input  logic [NUM_CH-1:0]        ch_rvalid,
   input  logic [NUM_CH*DATA_W-1:0] ch_rdata,
   output logic [NUM_CH-1:0]        ch_rready,
   input  logic                     inbuf_full,
   output logic                     inbuf_push,
   output logic [DATA_W-1:0]        data_to_inbuf
);

   localparam int BPB    = DATA_W / 8;
   localparam int BPB_LG = $clog2(BPB);
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

   function automatic logic [TX_SIZE_W-1:0] burst_of(input logic [TX_SIZE_W-1:0] rem);
      burst_of = (rem > TX_SIZE_W'(BURST_LEN)) ? TX_SIZE_W'(BURST_LEN) : rem;
   endfunction

   function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
      next_ch = (32'(c) == NUM_CH - 1) ? '0 : c + 1'b1;
   endfunction

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      next_ptr = (32'(p) == FIFO_DEPTH - 1) ? '0 : p + 1'b1;
   endfunction

   state_t                           state_q, state_d;
   logic [ADDR_W-1:0]                addr_q, addr_d;
   logic [TX_SIZE_W-1:0]             issue_rem_q, issue_rem_d;
   logic [CH_W-1:0]                  ic_q, ic_d;
   logic [NUM_CH-1:0]                req_q, req_d;
   logic [NUM_CH-1:0][ADDR_W-1:0]    ch_addr_q, ch_addr_d;
   logic [NUM_CH-1:0][3:0]           ch_len_q, ch_len_d;
   logic [NUM_CH-1:0][CNT_W-1:0]     credit_q, credit_d;
   logic                             zdone_q, zdone_d;
   logic [CH_W-1:0]                  mc_q, mc_d;
   logic [TX_SIZE_W-1:0]             burst_left_q, burst_left_d;
   logic [TX_SIZE_W-1:0]             merge_rem_q, merge_rem_d;

   logic [DATA_W-1:0]                mem [NUM_CH][FIFO_DEPTH];
   logic [NUM_CH-1:0][PTR_W-1:0]     wptr_q, rptr_q;
   logic [NUM_CH-1:0][CNT_W-1:0]     cnt_q;

   logic [NUM_CH-1:0]                hs, wr_vec, pop_vec;
   logic [TX_SIZE_W-1:0]             issue_len;
   logic                             pop;

   assign hs        = req_q & ch_ready;
   assign issue_len = burst_of(issue_rem_q);
   assign pop       = (cnt_q[mc_q] != '0) && !inbuf_full && (merge_rem_q != '0);
   assign pop_vec   = pop ? (NUM_CH'(1) << mc_q) : '0;
   assign wr_vec    = ch_rvalid & ch_rready;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      issue_rem_d  = issue_rem_q;
      ic_d         = ic_q;
      req_d        = '0;
      ch_addr_d    = ch_addr_q;
      ch_len_d     = ch_len_q;
      zdone_d      = 1'b0;
      mc_d         = mc_q;
      burst_left_d = burst_left_q;
      merge_rem_d  = merge_rem_q;
      for (int c = 0; c < NUM_CH; c++) begin
         credit_d[c] = credit_q[c] + CNT_W'(pop_vec[c]) - (hs[c] ? CNT_W'(issue_len) : '0);
      end

      if (pop) begin
         merge_rem_d = merge_rem_q - 1'b1;
         if (burst_left_q == TX_SIZE_W'(1)) begin
            mc_d         = next_ch(mc_q);
            burst_left_d = burst_of(merge_rem_q - 1'b1);
         end else begin
            burst_left_d = burst_left_q - 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (rd_req) begin
               if (rd_req_size == '0) begin
                  zdone_d = 1'b1;
               end else begin
                  state_d      = S_ISSUE;
                  addr_d       = rd_addr;
                  issue_rem_d  = rd_req_size;
                  ic_d         = '0;
                  merge_rem_d  = rd_req_size;
                  mc_d         = '0;
                  burst_left_d = burst_of(rd_req_size);
               end
            end
         end
         S_ISSUE: begin
            if (|hs) begin
               addr_d      = addr_q + (ADDR_W'(issue_len) << BPB_LG);
               issue_rem_d = issue_rem_q - issue_len;
               ic_d        = next_ch(ic_q);
               if (issue_rem_d == '0) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (merge_rem_q == '0) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Evaluated on next-cycle values so a new burst can follow a handshake immediately.
      if (state_d == S_ISSUE && 32'(credit_d[ic_d]) >= 32'(burst_of(issue_rem_d))) begin
         req_d[ic_d]     = 1'b1;
         ch_addr_d[ic_d] = addr_d;
         ch_len_d[ic_d]  = 4'(burst_of(issue_rem_d) - 1'b1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         issue_rem_q  <= '0;
         ic_q         <= '0;
         req_q        <= '0;
         ch_addr_q    <= '0;
         ch_len_q     <= '0;
         credit_q     <= {NUM_CH{CNT_W'(FIFO_DEPTH)}};
         zdone_q      <= 1'b0;
         mc_q         <= '0;
         burst_left_q <= '0;
         merge_rem_q  <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         issue_rem_q  <= issue_rem_d;
         ic_q         <= ic_d;
         req_q        <= req_d;
         ch_addr_q    <= ch_addr_d;
         ch_len_q     <= ch_len_d;
         credit_q     <= credit_d;
         zdone_q      <= zdone_d;
         mc_q         <= mc_d;
         burst_left_q <= burst_left_d;
         merge_rem_q  <= merge_rem_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (wr_vec[c])  wptr_q[c] <= next_ptr(wptr_q[c]);
            if (pop_vec[c]) rptr_q[c] <= next_ptr(rptr_q[c]);
            cnt_q[c] <= cnt_q[c] + CNT_W'(wr_vec[c]) - CNT_W'(pop_vec[c]);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (wr_vec[c]) mem[c][wptr_q[c]] <= ch_rdata[c*DATA_W +: DATA_W];
      end
   end

   // Credits bound outstanding beats to the FIFO depth, so an engine never sees a full FIFO with data pending.
   always_ff @(posedge clk) begin
      if (!reset) begin
         a_no_overflow: assert ((ch_rvalid & ~ch_rready) == '0);
      end
   end

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         ch_rready[c] = (cnt_q[c] != CNT_W'(FIFO_DEPTH));
      end
   end

   assign rd_ready      = (state_q == S_IDLE);
   assign rd_done       = zdone_q || (state_q == S_DRAIN && merge_rem_q == '0);
   assign ch_req        = req_q;
   assign ch_addr       = ch_addr_q;
   assign ch_len        = ch_len_q;
   assign inbuf_push    = pop;
   assign data_to_inbuf = (cnt_q[mc_q] != '0) ? mem[mc_q][rptr_q[mc_q]] : '0;

endmodule

// File: tb/tb_axi_read_stripe_merger.sv
// Randomized bench for axi_read_stripe_merger: engine models answer issued bursts,
// a burst/beat scoreboard built from the request checks striping, order and timing.
module tb_axi_read_stripe_merger;
   localparam int NC = 2, AW = 32, DW = 64, SW = 10, BL = 4, FD = 8, BPB = 8;

   logic              clk = 1'b0, reset = 1'b1;
   logic              rd_req = 1'b0, rd_ready, rd_done;
   logic [AW-1:0]     rd_addr = '0;
   logic [SW-1:0]     rd_req_size = '0;
   logic [NC-1:0]     ch_req, ch_ready = '0, ch_rvalid = '0, ch_rready;
   logic [NC*AW-1:0]  ch_addr;
   logic [NC*4-1:0]   ch_len;
   logic [NC*DW-1:0]  ch_rdata = '0;
   logic              inbuf_full = 1'b0, inbuf_push;
   logic [DW-1:0]     data_to_inbuf;

   axi_read_stripe_merger #(.NUM_CH(NC), .ADDR_W(AW), .DATA_W(DW), .TX_SIZE_W(SW),
                            .BURST_LEN(BL), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .reset(reset), .rd_req(rd_req), .rd_ready(rd_ready), .rd_addr(rd_addr),
      .rd_req_size(rd_req_size), .rd_done(rd_done), .ch_req(ch_req), .ch_ready(ch_ready),
      .ch_addr(ch_addr), .ch_len(ch_len), .ch_rvalid(ch_rvalid), .ch_rdata(ch_rdata),
      .ch_rready(ch_rready), .inbuf_full(inbuf_full), .inbuf_push(inbuf_push),
      .data_to_inbuf(data_to_inbuf));

   always #5 clk = ~clk;

   typedef struct {int ch; logic [31:0] a; int len;} burst_t;

   int checks = 0, fails = 0, cyc = 0;
   logic [31:0] eng_q [NC][$];
   burst_t      exp_b[$];
   logic [63:0] exp_d[$];
   int          exp_c[$];
   int outst[NC], hs_ch[NC], sil[NC];
   int hs_cnt, push_cnt, acc_cyc, last_push_cyc, done_cyc;
   int pv = 100, pr = 100, fullp = 0;
   bit active, zero_req, first_req_pend, ready_pend, acc_seen, rst_chk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [63:0] beat(input logic [31:0] a);
      return {a ^ 32'h5A5A_0F0F, a * 32'h9E37_79B1};
   endfunction

   task automatic build(input logic [31:0] a, input int size);
      for (int k = 0; k * BL < size; k++) begin
         int len;
         len = (size - k * BL < BL) ? size - k * BL : BL;
         exp_b.push_back('{k % NC, a + 32'(k * BL * BPB), len});
         for (int i = 0; i < len; i++) begin
            exp_d.push_back(beat(a + 32'((k * BL + i) * BPB)));
            exp_c.push_back(k % NC);
         end
      end
   endtask

   task automatic clear_model();
      for (int c = 0; c < NC; c++) begin
         eng_q[c].delete();
         outst[c] = 0;
         hs_ch[c] = 0;
      end
      exp_b.delete(); exp_d.delete(); exp_c.delete();
      active = 0; first_req_pend = 0; ready_pend = 0;
   endtask

   task automatic monitor();
      if (rst_chk) begin
         rst_chk = 0;
         chk("rst_rd_ready", rd_ready, 1);
         chk("rst_rd_done", rd_done, 0);
         chk("rst_ch_req", ch_req, 0);
         chk("rst_ch_addr", ch_addr, 0);
         chk("rst_ch_len", ch_len, 0);
         chk("rst_ch_rready", ch_rready, {NC{1'b1}});
         chk("rst_inbuf_push", inbuf_push, 0);
         chk("rst_data", data_to_inbuf, 0);
      end
      if (reset) return;
      if (ch_req != '0) chk("req_onehot", $countones(ch_req), 1);
      if (first_req_pend && ch_req != '0) begin
         chk("first_req_lat", cyc, acc_cyc + 1);
         first_req_pend = 0;
      end
      for (int c = 0; c < NC; c++) begin
         if (ch_rvalid[c]) begin
            chk("rready", ch_rready[c], 1);
            if (ch_rready[c] && eng_q[c].size() > 0) void'(eng_q[c].pop_front());
         end
         if (ch_req[c] && ch_ready[c]) begin
            logic [31:0] a;
            int n;
            a = ch_addr[c*AW +: AW];
            n = int'(ch_len[c*4 +: 4]) + 1;
            if (exp_b.size() == 0) chk("extra_burst", 1, 0);
            else begin
               burst_t b;
               b = exp_b.pop_front();
               chk("burst_ch", c, b.ch);
               chk("burst_addr", a, b.a);
               chk("burst_len", n - 1, b.len - 1);
               chk("credit", (outst[c] + b.len) <= FD, 1);
               outst[c] += b.len;
            end
            hs_cnt++;
            hs_ch[c]++;
            for (int i = 0; i < n; i++) eng_q[c].push_back(a + 32'(i * BPB));
         end
      end
      if (inbuf_push) begin
         chk("push_while_full", inbuf_full, 0);
         if (exp_d.size() == 0) chk("extra_push", 1, 0);
         else begin
            int ch;
            chk("push_data", data_to_inbuf, exp_d.pop_front());
            ch = exp_c.pop_front();
            outst[ch]--;
         end
         push_cnt++;
         last_push_cyc = cyc;
      end
      if (ready_pend && cyc == done_cyc + 1) begin
         chk("ready_after_done", rd_ready, 1);
         ready_pend = 0;
      end
      if (rd_done) begin
         if (!active) chk("spurious_done", 1, 0);
         else begin
            chk("done_lat", cyc, zero_req ? acc_cyc + 1 : last_push_cyc + 1);
            chk("ready_in_done", rd_ready, zero_req);
            chk("done_beats_left", exp_d.size(), 0);
            chk("done_bursts_left", exp_b.size(), 0);
            active = 0;
            done_cyc = cyc;
            ready_pend = 1;
         end
      end
      if (rd_req && rd_ready) begin
         acc_seen = 1;
         active = 1;
         acc_cyc = cyc;
         zero_req = (rd_req_size == '0);
         first_req_pend = !zero_req;
         build(rd_addr, int'(rd_req_size));
      end
   endtask

   task automatic drive();
      logic [NC-1:0] v, r;
      v = '0;
      r = '0;
      for (int c = 0; c < NC; c++) begin
         r[c] = ($urandom_range(99) < pr);
         if (!reset && sil[c] == 0 && eng_q[c].size() > 0) begin
            v[c] = ($urandom_range(99) < pv);
            ch_rdata[c*DW +: DW] = beat(eng_q[c][0]);
         end else begin
            ch_rdata[c*DW +: DW] = '0;
         end
      end
      ch_rvalid = v;
      ch_ready = r;
      if (fullp > 0) inbuf_full = ($urandom_range(99) < fullp);
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      cyc++;
      #1;
      drive();
   endtask

   task automatic reset_pulse();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      clear_model();
      rst_chk = 1;
      tick();
   endtask

   task automatic start_req(input logic [31:0] a, input int size);
      int n;
      push_cnt = 0;
      hs_cnt = 0;
      for (int c = 0; c < NC; c++) hs_ch[c] = 0;
      rd_addr = a;
      rd_req_size = SW'(size);
      rd_req = 1'b1;
      acc_seen = 0;
      n = 0;
      while (!acc_seen && n < 50) begin
         tick();
         n++;
      end
      rd_req = 1'b0;
      if (!acc_seen) chk("accept_timeout", 0, 1);
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (active && n < budget) begin
         tick();
         n++;
      end
      if (active) begin
         chk("done_timeout", 0, 1);
         reset_pulse();
      end
      tick();
      tick();
   endtask

   task automatic wait_pushes(input int target);
      int n;
      n = 0;
      while (push_cnt < target && n < 300) begin
         tick();
         n++;
      end
      if (push_cnt < target) chk("push_timeout", push_cnt, target);
   endtask

   initial begin
      int p0;
      clear_model();
      for (int c = 0; c < NC; c++) sil[c] = 0;
      repeat (2) tick();
      reset_pulse();

      // Striping and order: ch1 returns while ch0 is held back
      sil[0] = 1;
      start_req(32'h1000, 16);
      repeat (25) tick();
      chk("stripe_hs_ch0", hs_ch[0], 2);
      chk("stripe_hs_ch1", hs_ch[1], 2);
      chk("order_hold", push_cnt, 0);
      sil[0] = 0;
      wait_done(200);
      chk("stripe_pushes", push_cnt, 16);

      // Short tail
      start_req(32'h2000, 10);
      wait_done(200);
      chk("tail_pushes", push_cnt, 10);
      chk("tail_bursts", hs_cnt, 3);

      // Backpressure window
      pv = 70;
      start_req(32'h3000, 40);
      wait_pushes(6);
      inbuf_full = 1'b1;
      p0 = push_cnt;
      repeat (20) tick();
      chk("bp_no_push", push_cnt, p0);
      inbuf_full = 1'b0;
      wait_done(500);
      chk("bp_pushes", push_cnt, 40);

      // Credit stall with ch0 silent
      pv = 100;
      sil[0] = 1;
      start_req(32'h4000, 64);
      repeat (60) tick();
      chk("stall_hs_ch0", hs_ch[0], 2);
      chk("stall_hs_total", hs_cnt, 4);
      chk("stall_req_low", ch_req, 0);
      chk("stall_pushes", push_cnt, 0);
      sil[0] = 0;
      wait_done(800);
      chk("stall_total_pushes", push_cnt, 64);

      // Zero size
      start_req(32'h5000, 0);
      wait_done(10);
      chk("zero_pushes", push_cnt, 0);
      chk("zero_bursts", hs_cnt, 0);

      // Reset mid-operation, then a fresh request
      start_req(32'h6000, 32);
      wait_pushes(5);
      reset_pulse();
      repeat (6) tick();
      start_req(32'h6100, 8);
      wait_done(200);
      chk("post_rst_pushes", push_cnt, 8);

      // Randomized requests, including an address wrap
      for (int t = 0; t < 12; t++) begin
         logic [31:0] a;
         int s;
         pv = $urandom_range(30, 100);
         pr = $urandom_range(30, 100);
         fullp = $urandom_range(0, 30);
         a = (t == 3) ? 32'hFFFF_FFE0 : ($urandom() & 32'hFFFF_FFF8);
         s = $urandom_range(1, 60);
         start_req(a, s);
         wait_done(3000);
         chk("rand_pushes", push_cnt, s);
      end
      fullp = 0;
      inbuf_full = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
